// File: rtl/phase_detector_dl.sv
// Digital phase detector for the ADPLL loop.
// Each input is synchronized, then any transition on it counts as an event.
// The signed distance between a reference event and a generated event is
// measured in fast-clock cycles and held on pd_clock_cycles_o.
`timescale 1ns/1ps
module phase_detector_dl #(
    parameter int unsigned COUNT_WIDTH    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                   fpga_clk_i,
    input  logic                   reset_i,
    input  logic                   reference_i,
    input  logic                   generated_i,
    output logic [COUNT_WIDTH-1:0] pd_clock_cycles_o
);

    localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SAT_MAX = (2 ** (COUNT_WIDTH - 1)) - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        GEN_FIRST = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [2:0]             r_ref_pipe;
    logic [2:0]             r_gen_pipe;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_idle;
    logic [COUNT_WIDTH-1:0] r_pd;

    logic                   w_ref_ev;
    logic                   w_gen_ev;
    logic                   w_ev_any;
    logic [CNT_W-1:0]       w_cnt_inc;
    logic                   w_timeout;
    logic                   w_idle_hit;
    logic [COUNT_WIDTH-1:0] w_mag;
    logic [COUNT_WIDTH-1:0] w_sat;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_idle_nxt;
    logic [COUNT_WIDTH-1:0] w_pd_nxt;

    // Two synchronizer flops plus one history flop per input
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            r_ref_pipe <= 3'b000;
            r_gen_pipe <= 3'b000;
        end else begin
            r_ref_pipe <= {r_ref_pipe[1:0], reference_i};
            r_gen_pipe <= {r_gen_pipe[1:0], generated_i};
        end
    end

    assign w_ref_ev   = r_ref_pipe[2] ^ r_ref_pipe[1];
    assign w_gen_ev   = r_gen_pipe[2] ^ r_gen_pipe[1];
    assign w_ev_any   = w_ref_ev | w_gen_ev;
    assign w_cnt_inc  = r_cnt + CNT_W'(1);
    assign w_timeout  = (w_cnt_inc >= CNT_W'(TIMEOUT_CYCLES));
    assign w_idle_hit = !w_ev_any && (r_idle == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_sat      = COUNT_WIDTH'(SAT_MAX);
    assign w_mag      = (32'(w_cnt_inc) > SAT_MAX) ? w_sat : COUNT_WIDTH'(w_cnt_inc);

    // State register
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: partner event wins over a repeat event in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_ref_ev && !w_gen_ev)      w_state_nxt = REF_FIRST;
                else if (w_gen_ev && !w_ref_ev) w_state_nxt = GEN_FIRST;
            end
            REF_FIRST: begin
                if (w_gen_ev)       w_state_nxt = IDLE;
                else if (w_ref_ev)  w_state_nxt = REF_FIRST;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            GEN_FIRST: begin
                if (w_ref_ev)       w_state_nxt = IDLE;
                else if (w_gen_ev)  w_state_nxt = GEN_FIRST;
                else if (w_timeout) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Counter, idle timer and output next values; a measurement result overrides the idle clear
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_pd_nxt   = r_pd;
        w_idle_nxt = r_idle;
        if (w_ev_any) begin
            w_idle_nxt = '0;
        end else if (r_idle != CNT_W'(TIMEOUT_CYCLES)) begin
            w_idle_nxt = r_idle + CNT_W'(1);
        end
        if (w_idle_hit) begin
            w_pd_nxt = '0;
        end
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_ref_ev && w_gen_ev) w_pd_nxt = '0;
            end
            REF_FIRST: begin
                if (w_gen_ev) begin
                    w_pd_nxt  = w_mag;
                    w_cnt_nxt = '0;
                end else if (w_ref_ev) begin
                    w_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_pd_nxt  = w_sat;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            GEN_FIRST: begin
                if (w_ref_ev) begin
                    w_pd_nxt  = ~w_mag + COUNT_WIDTH'(1);
                    w_cnt_nxt = '0;
                end else if (w_gen_ev) begin
                    w_cnt_nxt = '0;
                end else if (w_timeout) begin
                    w_pd_nxt  = ~w_sat + COUNT_WIDTH'(1);
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge fpga_clk_i) begin
        if (!reset_i) begin
            r_cnt  <= '0;
            r_idle <= '0;
            r_pd   <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_idle <= w_idle_nxt;
            r_pd   <= w_pd_nxt;
        end
    end

    assign pd_clock_cycles_o = r_pd;

endmodule

// File: tb/tb_phase_detector_dl.sv
// Directed bench for phase_detector_dl: table of edge offsets plus
// hand-written sequences for timeouts, restart and reset corner cases.
`timescale 1ns/1ps
module tb_phase_detector_dl;

    logic              clk     = 1'b0;
    logic              rst_n   = 1'b0;
    logic              ref_i   = 1'b0;
    logic              gen_i   = 1'b0;
    logic [7:0]        pd;
    logic signed [7:0] pds;
    int                n_checks = 0;
    int                n_fail   = 0;

    typedef struct {
        int ra;
        int ga;
        int exp;
    } vec_t;

    vec_t vecs[13];

    assign pds = pd;

    always #1.25 clk = ~clk;

    phase_detector_dl #(
        .COUNT_WIDTH   (8),
        .TIMEOUT_CYCLES(256)
    ) dut (
        .fpga_clk_i       (clk),
        .reset_i          (rst_n),
        .reference_i      (ref_i),
        .generated_i      (gen_i),
        .pd_clock_cycles_o(pd)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Toggle reference at cycles ra/rb and generated at ga/gb (-1 = unused)
    task automatic drive_cycles(input int n, input int ra, input int rb, input int ga, input int gb);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == ra || c == rb) ref_i = ~ref_i;
            if (c == ga || c == gb) gen_i = ~gen_i;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{0,   0,    0};
        vecs[1]  = '{0,   4,    4};
        vecs[2]  = '{2,   0,   -2};
        vecs[3]  = '{0,   1,    1};
        vecs[4]  = '{0,   2,    2};
        vecs[5]  = '{0,   3,    3};
        vecs[6]  = '{5,   0,   -5};
        vecs[7]  = '{0,   127,  127};
        vecs[8]  = '{0,   128,  127};
        vecs[9]  = '{200, 0,   -127};
        vecs[10] = '{0,   255,  127};
        vecs[11] = '{3,   3,    0};
        vecs[12] = '{0,   7,    7};

        // Reset held while both inputs toggle together
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), int'(pds), 0);
            ref_i = ~ref_i;
            gen_i = ~gen_i;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release", int'(pds), 0);

        // Table of integer-cycle offsets
        for (int i = 0; i < 13; i++) begin
            n = (vecs[i].ra > vecs[i].ga) ? vecs[i].ra : vecs[i].ga;
            drive_cycles(n + 1, vecs[i].ra, -1, vecs[i].ga, -1);
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d", i), int'(pds), vecs[i].exp);
        end

        // 4 ns lag with edges not aligned to the fast clock
        @(posedge clk);
        #0.3 ref_i = ~ref_i;
        #4.0 gen_i = ~gen_i;
        repeat (8) @(negedge clk);
        check_range("async_4ns", int'(pds), 1, 2);

        // Both events together while waiting: partner completes
        drive_cycles(6, 0, 5, 5, -1);
        repeat (6) @(negedge clk);
        check("both_while_waiting", int'(pds), 5);

        // Restart on a repeated reference event
        drive_cycles(24, 0, 20, 23, -1);
        repeat (6) @(negedge clk);
        check("restart", int'(pds), 3);

        // Missing generated edge -> measurement timeout
        drive_cycles(1, 0, -1, -1, -1);
        n = 0;
        while (int'(pds) != 127 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_range("meas_timeout_latency", n, 255, 262);
        check("meas_timeout_value", int'(pds), 127);
        repeat (20) @(negedge clk);
        check("meas_timeout_hold", int'(pds), 127);

        // Reset in the middle of a measurement
        drive_cycles(6, 0, -1, -1, -1);
        rst_n = 1'b0;
        ref_i = 1'b0;
        gen_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_reset_out", int'(pds), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_reset_release", int'(pds), 0);
        drive_cycles(4, 3, -1, 0, -1);
        repeat (6) @(negedge clk);
        check("after_mid_reset", int'(pds), -3);

        // Idle timeout after a +6 measurement
        drive_cycles(7, 0, -1, 6, -1);
        n = 0;
        while (int'(pds) != 6 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_meas_latency", n, 3);
        n = 0;
        while (int'(pds) == 6 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_range("idle_timeout_cycles", n, 255, 256);
        check("idle_timeout_value", int'(pds), 0);
        repeat (50) @(negedge clk);
        check("idle_timeout_hold", int'(pds), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
